// File: rtl/sample_readout_if.sv
// Bundles the sample-RAM read port and the byte-wide TX handshake used by sample_readout.
// The readout engine is the master of both; the RAM/transmitter side is the slave.
interface sample_readout_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_cs;
  logic              ram_oe;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output ram_addr, ram_cs, ram_oe, tx_data, tx_valid,
    input  ram_data, tx_ready
  );

  modport slave (
    input  ram_addr, ram_cs, ram_oe, tx_data, tx_valid,
    output ram_data, tx_ready
  );
endinterface

// File: rtl/sample_readout.sv
// Streams a header byte and then a circular window of the sample RAM to the UART TX.
// One RAM fetch per sample; every outgoing byte is held in a register until handshaked.
module sample_readout #(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] HEADER = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  sample_readout_if.master  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   rem;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic              tx_fire;

  assign tx_fire = tx_valid_q && bus.tx_ready;

  // NOTE: all state updates use non-blocking assignments so every register in this
  // block samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      rem        <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ptr        <= start_addr;
            rem        <= length;
            tx_data_q  <= HEADER;
            tx_valid_q <= 1'b1;
            state      <= S_HEADER;
          end
        end
        S_HEADER, S_SEND: begin
          // rem already counts the byte in flight, so zero means this was the last one.
          if (tx_fire) begin
            tx_valid_q <= 1'b0;
            state      <= (rem == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          tx_data_q  <= bus.ram_data;
          tx_valid_q <= 1'b1;
          ptr        <= ptr + 1'b1;
          rem        <= rem - 1'b1;
          state      <= S_SEND;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Every output is a decode of registered state, so tx_ready never reaches an output.
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign bus.ram_cs   = (state == S_FETCH);
  assign bus.ram_oe   = (state == S_FETCH);
  assign bus.ram_addr = ptr;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

endmodule

// File: doc/sample_readout.md
# sample_readout

Drains a captured sample window out of the oscilloscope's sample RAM (synchronous write / asynchronous read, 8-bit address) and streams it byte-wise to the serial transmitter over a valid/ready handshake. It is the read-side counterpart of the capture path that fills the RAM. It sits between the sample RAM read port and the UART TX. Each readout emits one header byte followed by `length` samples, starting at `start_addr` and wrapping circularly through the address space.

## Interface
- `ADDR_W`, default 8: RAM address width. The buffer holds 2^ADDR_W samples.
- `DATA_W`, default 8: sample and TX byte width.
- `HEADER`, default 8'hA5: frame header byte, sent before the samples.

- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request a readout. Sampled only in IDLE.
- `start_addr`  in  ADDR_W: first RAM address to read. Latched on an accepted `start`.
- `length`  in  ADDR_W+1: number of samples, 0..2^ADDR_W. Latched on an accepted `start`.
- `busy`  out  1: high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1: one-cycle pulse when the frame is complete.
- `ram_addr`  out  ADDR_W: RAM read address.
- `ram_cs`  out  1: RAM chip select.
- `ram_oe`  out  1: RAM output enable.
- `ram_data`  in  DATA_W: RAM read data, valid combinationally from `ram_addr` while `ram_oe`=1.
- `tx_data`  out  DATA_W: byte to the transmitter (registered).
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: the transmitter accepts the byte.

## Operation
- The FSM has five states: IDLE, HEADER, FETCH, SEND, DONE.
- **IDLE**
  - On `start`=1: latch `ptr`<=`start_addr` and `rem`<=`length`.
  - Load `tx_data`<=HEADER, set `tx_valid`<=1, go to HEADER.
- **HEADER**
  - Hold until a transfer occurs (`tx_valid`&`tx_ready` at the edge).
  - On transfer: clear `tx_valid`. Go to DONE if `rem`==0, else go to FETCH.
- **FETCH** (exactly one cycle)
  - Drive `ram_cs`=`ram_oe`=1 and `ram_addr`=`ptr`.
  - At the edge: `tx_data`<=`ram_data`, `tx_valid`<=1, `ptr`<=`ptr`+1 (mod 2^ADDR_W, so 0xFF wraps to 0x00), `rem`<=`rem`-1.
  - Go to SEND.
- **SEND**
  - Hold `tx_data` and `tx_valid` stable until transfer.
  - On transfer: clear `tx_valid`. Go to DONE if `rem`==0, else go to FETCH.
- **DONE**
  - `done`=1 for this one cycle. Go to IDLE.
- `ram_cs`/`ram_oe` are 0 in every state except FETCH. In all other states `ram_addr` shows `ptr`.
- `busy` is 1 in every state except IDLE.
- `start` while `busy` is ignored. Latched parameters never change mid-frame.
- A `length` of 2^ADDR_W reads every location exactly once, ending at `start_addr`-1.
- `tx_valid` never drops without a transfer. `tx_data` never changes while `tx_valid`=1 and `tx_ready`=0.

## Timing
- Reset value of every output is 0: `busy`, `done`, `ram_addr`, `ram_cs`, `ram_oe`, `tx_data`, `tx_valid`.
- Reset also clears `ptr` and `rem`, and sets the state to IDLE.
- Reset mid-frame: on the next edge `tx_valid`=0, `busy`=0, and no `done` pulse is generated.
- With `tx_ready` held at 1, measured from the edge where `start` is sampled (cycle 0):
  - Header valid in cycle 1.
  - Sample k (k from 0) is fetched in cycle 2+2k and valid in cycle 3+2k.
  - `done`=1 in cycle 2+2·`length`; `busy` falls in the following cycle.
- Peak throughput is one sample per 2 cycles.
- Each cycle `tx_ready` is low while `tx_valid`=1 adds exactly one stall cycle.
- There is no combinational path from `tx_ready` to any output.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs -> every output is 0, and `start` during `rst` is ignored.
- **Basic frame:**
  - Stimulus: preload RAM[0x10..0x12]=0x11,0x22,0x33; `start_addr`=0x10, `length`=3, `tx_ready`=1.
  - Required: TX bytes A5,11,22,33 in cycles 1,3,5,7; `ram_oe` high in cycles 2,4,6 only; `done` in cycle 8; `busy` is 0 in cycle 9.
- **Wrap-around:**
  - Stimulus: RAM[0xFE,0xFF,0x00,0x01]=0xC1..0xC4; `start_addr`=0xFE, `length`=4.
  - Required: `ram_addr` sequence FE,FF,00,01; TX bytes A5,C1,C2,C3,C4.
- **Backpressure:**
  - Stimulus: same as the basic frame, but `tx_ready`=0 for 3 cycles while byte 0x22 is valid.
  - Required: `tx_data` stays 0x22 and `tx_valid` stays 1 throughout; no byte is lost or duplicated; `done` moves to cycle 11.
- **Zero length:** `length`=0 -> only A5 is sent, `ram_oe` never asserts, `done` in cycle 2.
- **Disturbance:**
  - `start` pulsed mid-frame with a different `start_addr` -> stream unchanged.
  - Then `rst` during SEND -> `tx_valid`=0 next cycle, no `done`.
  - Then a fresh `start` -> correct full frame.
